// File: rtl/veer_trace_sink_pkg.sv
// Shared trace-sink types: core trace packet, buffered FIFO entry and serialized record.
// RV_TRACE_SINK_TVAL_EN adds the per-entry trap value to the FIFO entry.
package veer_trace_sink_pkg;

  localparam int TRACE_LANES = 3;

  typedef struct packed {
    logic [TRACE_LANES-1:0]    valid_ip;
    logic [32*TRACE_LANES-1:0] insn_ip;
    logic [32*TRACE_LANES-1:0] address_ip;
    logic [TRACE_LANES-1:0]    exception_ip;
    logic [TRACE_LANES-1:0]    interrupt_ip;
    logic [4:0]                ecause_ip;
    logic [31:0]               tval_ip;
  } trace_pkt_t;

  typedef struct packed {
    logic [TRACE_LANES-1:0]    valid;
    logic [32*TRACE_LANES-1:0] insn;
    logic [32*TRACE_LANES-1:0] addr;
    logic [TRACE_LANES-1:0]    exc;
    logic [TRACE_LANES-1:0]    intr;
    logic [4:0]                ecause;
`ifdef RV_TRACE_SINK_TVAL_EN
    logic [31:0]               tval;
`endif
    logic                      lost;
  } trace_ent_t;

  typedef struct packed {
    logic [1:0]  lane;
    logic [31:0] insn;
    logic [31:0] addr;
    logic        exc;
    logic        intr;
    logic [4:0]  ecause;
    logic [31:0] tval;
    logic        lost;
  } trace_rec_t;

  function automatic logic [1:0] lowest_lane(input logic [TRACE_LANES-1:0] m);
    if (m[0]) return 2'd0;
    if (m[1]) return 2'd1;
    return 2'd2;
  endfunction

  function automatic logic [31:0] lane_word(input logic [32*TRACE_LANES-1:0] w,
                                            input logic [1:0] l);
    case (l)
      2'd1:    return w[63:32];
      2'd2:    return w[95:64];
      default: return w[31:0];
    endcase
  endfunction

endpackage

// File: rtl/veer_trace_fifo.sv
// Generic synchronous FIFO; head word read straight from storage, push at full legal only with a pop.
// Latency: a pushed word is visible at the head the cycle after the write edge.
module veer_trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    cnt_d = cnt_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset: the head is only observed while cnt_q is nonzero.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_dat;
  end

  assign pop_dat = mem_q[rd_ptr_q];
  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);

endmodule

// File: rtl/veer_trace_sink.sv
// Trace sink: buffers 3-lane trace packets, emits one per-instruction record per cycle (valid/ready),
// earliest the cycle after sampling; drops+counts packets when full. RV_TRACE_SINK_TVAL_EN keeps tval.
module veer_trace_sink
  import veer_trace_sink_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  trace_pkt_t  trace_pkt,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [1:0]  out_lane,
  output logic [31:0] out_insn,
  output logic [31:0] out_addr,
  output logic        out_exc,
  output logic        out_intr,
  output logic [4:0]  out_ecause,
  output logic [31:0] out_tval,
  output logic        out_lost,
  output logic [15:0] drop_cnt,
  input  logic        clr_drop
);

  localparam int EW = $bits(trace_ent_t);

  trace_ent_t             push_ent, head_ent;
  logic [EW-1:0]          head_raw;
  logic                   fifo_full, fifo_empty;
  logic                   push, pop, drop, fire, last_lane;
  logic [TRACE_LANES-1:0] remain, lane_bit;
  logic [1:0]             lane;
  trace_rec_t             rec;

  logic [TRACE_LANES-1:0] done_q, done_d;
  logic [15:0]            drop_cnt_q, drop_cnt_d;
  logic                   lost_pend_q, lost_pend_d;

  always_comb begin
    push_ent        = '0;
    push_ent.valid  = trace_pkt.valid_ip;
    push_ent.insn   = trace_pkt.insn_ip;
    push_ent.addr   = trace_pkt.address_ip;
    push_ent.exc    = trace_pkt.exception_ip;
    push_ent.intr   = trace_pkt.interrupt_ip;
    push_ent.ecause = trace_pkt.ecause_ip;
`ifdef RV_TRACE_SINK_TVAL_EN
    push_ent.tval   = trace_pkt.tval_ip;
`endif
    push_ent.lost   = lost_pend_q & ~clr_drop;
  end

`ifndef RV_TRACE_SINK_TVAL_EN
  logic unused_tval;
  assign unused_tval = ^trace_pkt.tval_ip;
`endif

  veer_trace_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (push_ent),
    .pop      (pop),
    .pop_dat  (head_raw),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  assign head_ent = trace_ent_t'(head_raw);

  // done_q tracks lanes of the head entry already emitted; cleared whenever the head pops.
  always_comb begin
    remain    = head_ent.valid & ~done_q;
    lane      = lowest_lane(remain);
    lane_bit  = TRACE_LANES'(1) << lane;
    fire      = ~fifo_empty & out_ready;
    last_lane = ((remain & ~lane_bit) == '0);
    pop       = fire & last_lane;
    push      = (trace_pkt.valid_ip != '0) & (~fifo_full | pop);
    drop      = (trace_pkt.valid_ip != '0) & ~push;

    done_d = done_q;
    if (pop)       done_d = '0;
    else if (fire) done_d = done_q | lane_bit;

    drop_cnt_d  = drop_cnt_q;
    lost_pend_d = lost_pend_q;
    if (clr_drop) begin
      drop_cnt_d  = '0;
      lost_pend_d = 1'b0;
    end else if (drop) begin
      if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
      lost_pend_d = 1'b1;
    end else if (push) begin
      lost_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done_q      <= '0;
      drop_cnt_q  <= '0;
      lost_pend_q <= 1'b0;
    end else begin
      done_q      <= done_d;
      drop_cnt_q  <= drop_cnt_d;
      lost_pend_q <= lost_pend_d;
    end
  end

  // Record fields are zero when idle and derive only from registered state, so they hold under stall.
  always_comb begin
    rec = '0;
    if (!fifo_empty) begin
      rec.lane = lane;
      rec.insn = lane_word(head_ent.insn, lane);
      rec.addr = lane_word(head_ent.addr, lane);
      rec.exc  = head_ent.exc[lane];
      rec.intr = head_ent.intr[lane];
      if (head_ent.exc[lane] | head_ent.intr[lane]) begin
        rec.ecause = head_ent.ecause;
`ifdef RV_TRACE_SINK_TVAL_EN
        rec.tval   = head_ent.tval;
`endif
      end
      rec.lost = head_ent.lost & (done_q == '0);
    end
  end

  assign out_valid  = ~fifo_empty;
  assign out_lane   = rec.lane;
  assign out_insn   = rec.insn;
  assign out_addr   = rec.addr;
  assign out_exc    = rec.exc;
  assign out_intr   = rec.intr;
  assign out_ecause = rec.ecause;
  assign out_tval   = rec.tval;
  assign out_lost   = rec.lost;
  assign drop_cnt   = drop_cnt_q;

endmodule

// File: tb/tb_veer_trace_sink.sv
// Directed bench for veer_trace_sink: inputs driven after the falling edge, outputs checked there too.
module tb_veer_trace_sink;
  import veer_trace_sink_pkg::*;

  localparam int DEPTH = 4;
`ifdef RV_TRACE_SINK_TVAL_EN
  localparam logic [31:0] EXP_TVAL = 32'hDEADBEEF;
`else
  localparam logic [31:0] EXP_TVAL = 32'h0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  trace_pkt_t  trace_pkt;
  logic        out_valid, out_ready;
  logic [1:0]  out_lane;
  logic [31:0] out_insn, out_addr, out_tval;
  logic        out_exc, out_intr, out_lost;
  logic [4:0]  out_ecause;
  logic [15:0] drop_cnt;
  logic        clr_drop;

  int checks = 0;
  int errors = 0;

  veer_trace_sink #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .trace_pkt(trace_pkt),
    .out_valid(out_valid), .out_ready(out_ready), .out_lane(out_lane),
    .out_insn(out_insn), .out_addr(out_addr), .out_exc(out_exc), .out_intr(out_intr),
    .out_ecause(out_ecause), .out_tval(out_tval), .out_lost(out_lost),
    .drop_cnt(drop_cnt), .clr_drop(clr_drop)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic trace_pkt_t mk(input logic [2:0] v, input logic [31:0] i0,
                                    input logic [31:0] i1, input logic [31:0] i2);
    trace_pkt_t p;
    p = '0;
    p.valid_ip   = v;
    p.insn_ip    = {i2, i1, i0};
    p.address_ip = {32'h80000008, 32'h80000004, 32'h80000000};
    return p;
  endfunction

  task automatic test_reset;
    rst = 1'b1; out_ready = 1'b0; clr_drop = 1'b0; trace_pkt = '0;
    tick; tick;
    rst = 1'b0;
    tick;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%0b exp=0", out_valid); end
    checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL reset_drop got=%0d exp=0", drop_cnt); end
    checks++; if (out_insn !== 32'd0 || out_addr !== 32'd0) begin errors++; $display("FAIL reset_rec insn=%h addr=%h exp=0", out_insn, out_addr); end
    checks++; if (out_lost !== 1'b0 || out_tval !== 32'd0) begin errors++; $display("FAIL reset_lost lost=%0b tval=%h exp=0", out_lost, out_tval); end
  endtask

  task automatic test_single;
    trace_pkt = mk(3'b101, 32'h00000013, 32'h0, 32'h00100073);
    out_ready = 1'b1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_early got=%0b exp=0", out_valid); end
    tick;
    trace_pkt = '0;
    checks++; if (out_valid !== 1'b1 || out_lane !== 2'd0 || out_insn !== 32'h00000013 || out_addr !== 32'h80000000)
      begin errors++; $display("FAIL single_rec0 v=%0b lane=%0d insn=%h addr=%h exp 1/0/00000013/80000000", out_valid, out_lane, out_insn, out_addr); end
    tick;
    checks++; if (out_valid !== 1'b1 || out_lane !== 2'd2 || out_insn !== 32'h00100073 || out_addr !== 32'h80000008)
      begin errors++; $display("FAIL single_rec2 v=%0b lane=%0d insn=%h addr=%h exp 1/2/00100073/80000008", out_valid, out_lane, out_insn, out_addr); end
    tick;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL single_done got=%0b exp=0", out_valid); end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b0;
    trace_pkt = mk(3'b010, 32'h0, 32'hCAFE0001, 32'h0);
    tick;
    trace_pkt = '0;
    for (int i = 0; i < 5; i++) begin
      checks++; if (out_valid !== 1'b1 || out_lane !== 2'd1 || out_insn !== 32'hCAFE0001 || out_addr !== 32'h80000004 || out_lost !== 1'b0)
        begin errors++; $display("FAIL bp_hold%0d v=%0b lane=%0d insn=%h addr=%h exp 1/1/cafe0001/80000004", i, out_valid, out_lane, out_insn, out_addr); end
      tick;
    end
    out_ready = 1'b1;
    tick;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_once got=%0b exp=0", out_valid); end
  endtask

  task automatic test_overflow;
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 3; i++) begin
      trace_pkt = mk(3'b001, 32'h100 + i, 32'h0, 32'h0);
      tick;
    end
    trace_pkt = '0;
    checks++; if (drop_cnt !== 16'd3) begin errors++; $display("FAIL ovf_cnt got=%0d exp=3", drop_cnt); end
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      checks++; if (out_valid !== 1'b1 || out_insn !== 32'h100 + i || out_lost !== 1'b0)
        begin errors++; $display("FAIL ovf_drain%0d v=%0b insn=%h lost=%0b exp 1/%h/0", i, out_valid, out_insn, out_lost, 32'h100 + i); end
      tick;
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty got=%0b exp=0", out_valid); end
    trace_pkt = mk(3'b011, 32'hA0, 32'hA1, 32'h0);
    tick;
    trace_pkt = '0;
    checks++; if (out_lost !== 1'b1 || out_insn !== 32'hA0) begin errors++; $display("FAIL ovf_lost1 lost=%0b insn=%h exp 1/a0", out_lost, out_insn); end
    tick;
    checks++; if (out_lost !== 1'b0 || out_insn !== 32'hA1 || out_lane !== 2'd1) begin errors++; $display("FAIL ovf_lost0 lost=%0b insn=%h lane=%0d exp 0/a1/1", out_lost, out_insn, out_lane); end
    tick;
    clr_drop = 1'b1;
    tick;
    clr_drop = 1'b0;
    checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL ovf_clr got=%0d exp=0", drop_cnt); end
  endtask

  task automatic test_full_pop;
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      trace_pkt = mk(3'b001, 32'h200 + i, 32'h0, 32'h0);
      tick;
    end
    trace_pkt = mk(3'b001, 32'h200 + DEPTH, 32'h0, 32'h0);
    out_ready = 1'b1;
    tick;
    trace_pkt = '0;
    checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL fullpop_cnt got=%0d exp=0", drop_cnt); end
    for (int i = 1; i <= DEPTH; i++) begin
      checks++; if (out_valid !== 1'b1 || out_insn !== 32'h200 + i) begin errors++; $display("FAIL fullpop_rec%0d v=%0b insn=%h exp 1/%h", i, out_valid, out_insn, 32'h200 + i); end
      tick;
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL fullpop_empty got=%0b exp=0", out_valid); end
  endtask

  task automatic test_clr_vs_drop;
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      trace_pkt = mk(3'b001, 32'h300 + i, 32'h0, 32'h0);
      tick;
    end
    checks++; if (drop_cnt !== 16'd1) begin errors++; $display("FAIL clrdrop_pre got=%0d exp=1", drop_cnt); end
    clr_drop = 1'b1;
    tick;
    clr_drop = 1'b0;
    trace_pkt = '0;
    checks++; if (drop_cnt !== 16'd0) begin errors++; $display("FAIL clrdrop_win got=%0d exp=0", drop_cnt); end
    out_ready = 1'b1;
    repeat (DEPTH) tick;
    trace_pkt = mk(3'b001, 32'h3FF, 32'h0, 32'h0);
    tick;
    trace_pkt = '0;
    checks++; if (out_valid !== 1'b1 || out_lost !== 1'b0) begin errors++; $display("FAIL clrdrop_lost v=%0b lost=%0b exp 1/0", out_valid, out_lost); end
    tick;
  endtask

  task automatic test_exception;
    trace_pkt_t p;
    out_ready = 1'b0;
    p = mk(3'b001, 32'h00000073, 32'h0, 32'h0);
    p.exception_ip = 3'b001; p.ecause_ip = 5'd2; p.tval_ip = 32'hDEADBEEF;
    trace_pkt = p;
    tick;
    trace_pkt = '0;
    checks++; if (out_exc !== 1'b1 || out_intr !== 1'b0 || out_ecause !== 5'd2) begin errors++; $display("FAIL exc_flags exc=%0b intr=%0b ecause=%0d exp 1/0/2", out_exc, out_intr, out_ecause); end
    checks++; if (out_tval !== EXP_TVAL) begin errors++; $display("FAIL exc_tval got=%h exp=%h", out_tval, EXP_TVAL); end
    out_ready = 1'b1;
    tick;
    p.valid_ip = 3'b011; p.insn_ip[63:32] = 32'h00000013;
    trace_pkt = p;
    out_ready = 1'b0;
    tick;
    trace_pkt = '0;
    checks++; if (out_lane !== 2'd0 || out_exc !== 1'b1 || out_ecause !== 5'd2) begin errors++; $display("FAIL exc_lane0 lane=%0d exc=%0b ecause=%0d exp 0/1/2", out_lane, out_exc, out_ecause); end
    out_ready = 1'b1;
    tick;
    checks++; if (out_lane !== 2'd1 || out_exc !== 1'b0 || out_ecause !== 5'd0 || out_tval !== 32'd0)
      begin errors++; $display("FAIL exc_clean lane=%0d exc=%0b ecause=%0d tval=%h exp 1/0/0/0", out_lane, out_exc, out_ecause, out_tval); end
    tick;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL exc_empty got=%0b exp=0", out_valid); end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    for (int i = 0; i < DEPTH + 1; i++) begin
      trace_pkt = mk(3'b111, 32'h400 + i, 32'h500 + i, 32'h600 + i);
      tick;
    end
    trace_pkt = '0;
    out_ready = 1'b1;
    tick;
    checks++; if (out_lane !== 2'd1 || out_insn !== 32'h500 || drop_cnt !== 16'd1)
      begin errors++; $display("FAIL rstmid_pre lane=%0d insn=%h cnt=%0d exp 1/500/1", out_lane, out_insn, drop_cnt); end
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checks++; if (out_valid !== 1'b0 || drop_cnt !== 16'd0) begin errors++; $display("FAIL rstmid_post v=%0b cnt=%0d exp 0/0", out_valid, drop_cnt); end
    for (int i = 0; i < 4; i++) begin
      tick;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_resid%0d got=%0b exp=0", i, out_valid); end
    end
    trace_pkt = mk(3'b100, 32'h0, 32'h0, 32'h777);
    tick;
    trace_pkt = '0;
    checks++; if (out_valid !== 1'b1 || out_lane !== 2'd2 || out_insn !== 32'h777 || out_lost !== 1'b0)
      begin errors++; $display("FAIL rstmid_fresh v=%0b lane=%0d insn=%h lost=%0b exp 1/2/777/0", out_valid, out_lane, out_insn, out_lost); end
    tick;
  endtask

  initial begin
    test_reset;
    test_single;
    test_backpressure;
    test_overflow;
    test_full_pop;
    test_clr_vs_drop;
    test_exception;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
